mc_dispatcher: RTL and testbench
================================

MC_DISPATCHER -- requirements
Module: mc_dispatcher

Interface
REQ-001 Parameter NUM_CH, 2: number of request/response channel pairs (2..8).
REQ-002 Parameter ID_W, 8: request id width; IDX_W, 20: page index width; CNT_W, 4: page-count width; PTR_W, 6: FIFO pointer width.
REQ-003 Parameter MAX_PAGES, 8: largest legal page count (power of two, at most 2^CNT_W-1).
REQ-004 Parameter URGENT_THRESHOLD, 64: FIFO occupancy at or above which a channel is urgent.
REQ-005 Parameter SWITCH_GAP, 5: wait cycles inserted before a dispatch to a channel differing from the last dispatched one; SPIN_CYCLES, 2: idle cycles when nothing is eligible.
REQ-006 clk  in  1  sole clock; reset is synchronous and active-low.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 req_empty  in  NUM_CH  per-channel request FIFO empty.
REQ-009 req_data_count  in  NUM_CH*(PTR_W+1)  per-channel FIFO occupancy, channel c at slice c.
REQ-010 req_id / req_page_idx / req_page_count  in  NUM_CH*ID_W / NUM_CH*IDX_W / NUM_CH*CNT_W  FIFO head data, valid the cycle after pop.
REQ-011 req_pop  out  NUM_CH  one-hot pop strobe.
REQ-012 rsp_almost_full, ch_blocked  in  NUM_CH each  response FIFO almost full; downstream engine of channel busy.
REQ-013 disp_valid  out  1; disp_ch  out  clog2(NUM_CH); disp_id  out  ID_W; disp_page_idx  out  IDX_W; disp_size  out  clog2(clog2(MAX_PAGES)+1)  dispatch to engine.
REQ-014 rsp_write_en  out  NUM_CH  one-hot fail-response strobe; rsp_id  out  ID_W; rsp_fail_reason  out  FAIL_REASON_WIDTH.

Function
REQ-015 Channel c is eligible when !req_empty[c] && !rsp_almost_full[c] && !ch_blocked[c].
REQ-016 Grant: among eligible urgent channels (data_count >= URGENT_THRESHOLD) round-robin starting at rr_ptr; if none urgent, round-robin among all eligible; rr_ptr becomes grant+1 mod NUM_CH.
REQ-017 States: IDLE, FETCH, CHECK, SWITCH_WAIT, SPIN; default/illegal -> IDLE.
REQ-018 IDLE at cycle t: eligible channel exists -> latch grant, FETCH; else -> SPIN.
REQ-019 FETCH (t+1): req_pop[grant]=1 for exactly one cycle; -> CHECK.
REQ-020 CHECK (t+2): page_count 0 -> rsp_write_en[grant], rsp_fail_reason=FAIL_REASON_EQUAL_ZERO; page_count > MAX_PAGES -> FAIL_REASON_OVER_MAX; both at t+3 for one cycle, then -> IDLE, no dispatch.
REQ-021 CHECK legal count: disp_size = ceil(log2(page_count)) (1->0, 2->1, 3..4->2, 5..8->3); latch id, page_idx, ch.
REQ-022 Legal and grant == last_ch (or first dispatch since reset): disp_valid=1 at t+3 for one cycle, -> IDLE.
REQ-023 Legal and grant != last_ch: -> SWITCH_WAIT; disp_valid=1 at t+3+SWITCH_GAP for one cycle; -> IDLE.
REQ-024 last_ch updates only on a disp_valid pulse; failed requests never update it.
REQ-025 SPIN holds SPIN_CYCLES cycles, then -> IDLE.
REQ-026 disp_* data fields hold last value when disp_valid=0; rsp_id/rsp_fail_reason are 0 when no strobe.
REQ-027 Eligibility changes after IDLE do not cancel a grant; the popped request always completes.
REQ-028 At most one req_pop bit, one rsp_write_en bit, and never disp_valid together with rsp_write_en.

Reset
REQ-029 rst_n low at a clk edge: state=IDLE, rr_ptr=0, last_ch invalid, wait counter 0, every output 0, including mid-FETCH/CHECK/SWITCH_WAIT; an in-flight request is dropped.
REQ-030 No pop on the first cycle after reset release; earliest pop at cycle 2.

Structure
REQ-031 Size encodings, FAIL_REASON_WIDTH and fail codes belong in mmu_param.vh.
REQ-032 Urgency-aware round-robin grant is a sub-module, rr_arbiter, parameterised by NUM_CH.

Verification
REQ-033 NUM_CH=2, ch0 one request count=3, ch1 empty -> pop ch0 at t+1, disp_valid t+3, disp_size=2, disp_ch=0.
REQ-034 Back-to-back dispatch ch0 then ch1 count=8 -> second disp_valid SWITCH_GAP=5 cycles later than no-switch case, disp_size=3.
REQ-035 ch0 count=0, then count=9 -> rsp_write_en=01 with EQUAL_ZERO, then OVER_MAX; no disp_valid; last_ch unchanged.
REQ-036 ch0 data_count=10, ch1 data_count=64 -> ch1 granted first despite rr_ptr=0.
REQ-037 All channels blocked -> IDLE,SPIN,SPIN,IDLE loop, zero pops; rst_n low during SWITCH_WAIT -> all outputs 0 next cycle, no disp_valid.

Source files
------------

// File: rtl/mc_dispatcher_pkg.sv
// Shared types and constants for the memory-command dispatcher: FSM states,
// fail-response codes and the page-count to size-code mapping.
package mc_dispatcher_pkg;

  localparam int FAIL_REASON_WIDTH = 2;

  localparam logic [FAIL_REASON_WIDTH-1:0] FAIL_REASON_NONE       = 2'd0;
  localparam logic [FAIL_REASON_WIDTH-1:0] FAIL_REASON_EQUAL_ZERO = 2'd1;
  localparam logic [FAIL_REASON_WIDTH-1:0] FAIL_REASON_OVER_MAX   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_SWITCH_WAIT,
    ST_SPIN
  } state_t;

  // Size code is ceil(log2(page_count)): the bit length of (page_count - 1).
  function automatic int size_code(input int page_count);
    int s;
    s = 0;
    for (int b = 0; b < 31; b++) begin
      if (((page_count - 1) >> b) != 0) s = b + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/mc_dispatcher_rr_arbiter.sv
// Urgency-aware round-robin arbiter: urgent eligible channels win first,
// otherwise any eligible channel; the search starts at rr_ptr.
module rr_arbiter
  import mc_dispatcher_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [NUM_CH-1:0] urgent,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant
);

  logic            found_urgent;
  logic            found_any;
  logic [CH_W-1:0] grant_urgent;
  logic [CH_W-1:0] grant_any;
  int              idx;

  // Walk channels in rotated order and keep the first hit of each class.
  always_comb begin
    found_urgent = 1'b0;
    found_any    = 1'b0;
    grant_urgent = '0;
    grant_any    = '0;
    idx          = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!found_urgent && eligible[idx] && urgent[idx]) begin
        found_urgent = 1'b1;
        grant_urgent = CH_W'(idx);
      end
      if (!found_any && eligible[idx]) begin
        found_any = 1'b1;
        grant_any = CH_W'(idx);
      end
    end
    grant_valid = found_any;
    grant       = found_urgent ? grant_urgent : grant_any;
  end

endmodule

// File: rtl/mc_dispatcher.sv
// Dispatcher: arbitrates request FIFOs, pops one request, validates its page
// count, then either dispatches to the engine or writes a fail response.
module mc_dispatcher
  import mc_dispatcher_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int ID_W             = 8,
  parameter int IDX_W            = 20,
  parameter int CNT_W            = 4,
  parameter int PTR_W            = 6,
  parameter int MAX_PAGES        = 8,
  parameter int URGENT_THRESHOLD = 64,
  parameter int SWITCH_GAP       = 5,
  parameter int SPIN_CYCLES      = 2,
  parameter int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SIZE_W           = $clog2($clog2(MAX_PAGES) + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             req_empty,
  input  logic [NUM_CH*(PTR_W+1)-1:0]   req_data_count,
  input  logic [NUM_CH*ID_W-1:0]        req_id,
  input  logic [NUM_CH*IDX_W-1:0]       req_page_idx,
  input  logic [NUM_CH*CNT_W-1:0]       req_page_count,
  output logic [NUM_CH-1:0]             req_pop,
  input  logic [NUM_CH-1:0]             rsp_almost_full,
  input  logic [NUM_CH-1:0]             ch_blocked,
  output logic                          disp_valid,
  output logic [CH_W-1:0]               disp_ch,
  output logic [ID_W-1:0]               disp_id,
  output logic [IDX_W-1:0]              disp_page_idx,
  output logic [SIZE_W-1:0]             disp_size,
  output logic [NUM_CH-1:0]             rsp_write_en,
  output logic [ID_W-1:0]               rsp_id,
  output logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason
);

  localparam int WAIT_W = 8;

  state_t             state;
  logic [NUM_CH-1:0]  eligible;
  logic [NUM_CH-1:0]  urgent;
  logic               arb_valid;
  logic [CH_W-1:0]    arb_grant;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant;
  logic [CH_W-1:0]    last_ch;
  logic               last_valid;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   cur_count;
  logic [ID_W-1:0]    cur_id;
  logic [IDX_W-1:0]   cur_idx;
  logic [SIZE_W-1:0]  cur_size;
  logic [ID_W-1:0]    pend_id;
  logic [IDX_W-1:0]   pend_idx;
  logic [SIZE_W-1:0]  pend_size;

  // Per-channel eligibility and urgency from FIFO/backpressure status.
  always_comb begin
    eligible = '0;
    urgent   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eligible[c] = !req_empty[c] && !rsp_almost_full[c] && !ch_blocked[c];
      urgent[c]   = req_data_count[c*(PTR_W+1) +: (PTR_W+1)] >= (PTR_W+1)'(URGENT_THRESHOLD);
    end
  end

  // Head data of the granted channel, valid in CHECK (the cycle after pop).
  always_comb begin
    cur_count = req_page_count[int'(grant)*CNT_W +: CNT_W];
    cur_id    = req_id[int'(grant)*ID_W +: ID_W];
    cur_idx   = req_page_idx[int'(grant)*IDX_W +: IDX_W];
    cur_size  = SIZE_W'(size_code(int'(cur_count)));
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .eligible    (eligible),
    .urgent      (urgent),
    .rr_ptr      (rr_ptr),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // Dispatch FSM with registered strobes and held dispatch data fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      grant           <= '0;
      last_ch         <= '0;
      last_valid      <= 1'b0;
      wait_cnt        <= '0;
      pend_id         <= '0;
      pend_idx        <= '0;
      pend_size       <= '0;
      req_pop         <= '0;
      disp_valid      <= 1'b0;
      disp_ch         <= '0;
      disp_id         <= '0;
      disp_page_idx   <= '0;
      disp_size       <= '0;
      rsp_write_en    <= '0;
      rsp_id          <= '0;
      rsp_fail_reason <= FAIL_REASON_NONE;
    end else begin
      req_pop         <= '0;
      disp_valid      <= 1'b0;
      rsp_write_en    <= '0;
      rsp_id          <= '0;
      rsp_fail_reason <= FAIL_REASON_NONE;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant              <= arb_grant;
            rr_ptr             <= (arb_grant == CH_W'(NUM_CH - 1)) ? '0 : arb_grant + 1'b1;
            req_pop[arb_grant] <= 1'b1;
            state              <= ST_FETCH;
          end else begin
            wait_cnt <= WAIT_W'(SPIN_CYCLES - 1);
            state    <= ST_SPIN;
          end
        end
        ST_FETCH: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (cur_count == '0) begin
            rsp_write_en[grant] <= 1'b1;
            rsp_id              <= cur_id;
            rsp_fail_reason     <= FAIL_REASON_EQUAL_ZERO;
            state               <= ST_IDLE;
          end else if (cur_count > CNT_W'(MAX_PAGES)) begin
            rsp_write_en[grant] <= 1'b1;
            rsp_id              <= cur_id;
            rsp_fail_reason     <= FAIL_REASON_OVER_MAX;
            state               <= ST_IDLE;
          end else if (!last_valid || grant == last_ch) begin
            disp_valid    <= 1'b1;
            disp_ch       <= grant;
            disp_id       <= cur_id;
            disp_page_idx <= cur_idx;
            disp_size     <= cur_size;
            last_ch       <= grant;
            last_valid    <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            pend_id   <= cur_id;
            pend_idx  <= cur_idx;
            pend_size <= cur_size;
            wait_cnt  <= WAIT_W'(SWITCH_GAP - 1);
            state     <= ST_SWITCH_WAIT;
          end
        end
        ST_SWITCH_WAIT: begin
          if (wait_cnt == '0) begin
            disp_valid    <= 1'b1;
            disp_ch       <= grant;
            disp_id       <= pend_id;
            disp_page_idx <= pend_idx;
            disp_size     <= pend_size;
            last_ch       <= grant;
            last_valid    <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_SPIN: begin
          if (wait_cnt == '0) state <= ST_IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_dispatcher.sv
// Self-checking bench for mc_dispatcher (NUM_CH=2): FIFO models feed the DUT,
// a scoreboard holds expected dispatches/fail responses with pop-to-output latency.
module tb_mc_dispatcher;

  typedef struct packed {
    logic [7:0]  id;
    logic [19:0] idx;
    logic [3:0]  cnt;
  } req_t;

  typedef struct {
    bit          is_rsp;
    int          ch;
    logic [7:0]  id;
    logic [19:0] idx;
    logic [1:0]  size;
    logic [1:0]  reason;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_empty;
  logic [13:0] req_data_count;
  logic [15:0] req_id;
  logic [39:0] req_page_idx;
  logic [7:0]  req_page_count;
  logic [1:0]  req_pop;
  logic [1:0]  rsp_almost_full;
  logic [1:0]  ch_blocked;
  logic        disp_valid;
  logic [0:0]  disp_ch;
  logic [7:0]  disp_id;
  logic [19:0] disp_page_idx;
  logic [1:0]  disp_size;
  logic [1:0]  rsp_write_en;
  logic [7:0]  rsp_id;
  logic [1:0]  rsp_fail_reason;

  req_t fifo0[$];
  req_t fifo1[$];
  exp_t sb[$];
  int   ovr0;
  int   ovr1;
  int   cyc;
  int   pop_count;
  int   last_pop_cycle;
  int   compared;
  int   mismatched;
  int   snap;

  mc_dispatcher dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_empty       (req_empty),
    .req_data_count  (req_data_count),
    .req_id          (req_id),
    .req_page_idx    (req_page_idx),
    .req_page_count  (req_page_count),
    .req_pop         (req_pop),
    .rsp_almost_full (rsp_almost_full),
    .ch_blocked      (ch_blocked),
    .disp_valid      (disp_valid),
    .disp_ch         (disp_ch),
    .disp_id         (disp_id),
    .disp_page_idx   (disp_page_idx),
    .disp_size       (disp_size),
    .rsp_write_en    (rsp_write_en),
    .rsp_id          (rsp_id),
    .rsp_fail_reason (rsp_fail_reason)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive FIFO status signals from the queue models.
  function automatic void refresh();
    req_empty[0]        = (fifo0.size() == 0);
    req_empty[1]        = (fifo1.size() == 0);
    req_data_count[6:0]  = (ovr0 != 0) ? 7'(ovr0) : 7'(fifo0.size());
    req_data_count[13:7] = (ovr1 != 0) ? 7'(ovr1) : 7'(fifo1.size());
  endfunction

  // Expected outcome of one request; size is the smallest s with 2^s >= count.
  function automatic exp_t model(int ch, logic [7:0] id, logic [19:0] idx, logic [3:0] cnt, int lat);
    exp_t e;
    e.ch = ch; e.id = id; e.idx = idx; e.lat = lat;
    e.size = 2'd0; e.reason = 2'd0; e.is_rsp = 1'b0;
    if (cnt == 0) begin
      e.is_rsp = 1'b1; e.reason = 2'd1;
    end else if (cnt > 8) begin
      e.is_rsp = 1'b1; e.reason = 2'd2;
    end else begin
      for (int s = 3; s >= 0; s--) if ((1 << s) >= int'(cnt)) e.size = 2'(s);
    end
    return e;
  endfunction

  task automatic applyStimulus(input int ch, input logic [7:0] id, input logic [19:0] idx,
                               input logic [3:0] cnt, input int lat, input bit expect_out);
    req_t r;
    r = '{id: id, idx: idx, cnt: cnt};
    if (ch == 0) fifo0.push_back(r);
    else         fifo1.push_back(r);
    if (expect_out) sb.push_back(model(ch, id, idx, cnt, lat));
    refresh();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", sb.size(), 0);
  endtask

  task automatic waitPop(input int budget);
    int start;
    int n;
    start = pop_count;
    n = 0;
    while (pop_count == start && n < budget) begin
      tick();
      n++;
    end
    checkOutput("pop_timeout", pop_count - start, 1);
  endtask

  // Monitor: serve pops from the FIFO models and score every output strobe.
  always @(negedge clk) begin : mon
    req_t r;
    exp_t e;
    if (req_pop != 2'b00) begin
      checkOutput("pop_onehot", $countones(req_pop), 1);
      pop_count++;
      last_pop_cycle = cyc;
      if (req_pop[0] && fifo0.size() != 0) begin
        r = fifo0.pop_front();
        req_id[7:0] = r.id; req_page_idx[19:0] = r.idx; req_page_count[3:0] = r.cnt;
      end
      if (req_pop[1] && fifo1.size() != 0) begin
        r = fifo1.pop_front();
        req_id[15:8] = r.id; req_page_idx[39:20] = r.idx; req_page_count[7:4] = r.cnt;
      end
      refresh();
    end
    if (disp_valid || rsp_write_en != 2'b00) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", {disp_valid, rsp_write_en}, 0);
      end else begin
        e = sb.pop_front();
        if (e.is_rsp) begin
          checkOutput("rsp_strobe", {disp_valid, rsp_write_en}, {1'b0, 2'(1 << e.ch)});
          checkOutput("rsp_id", rsp_id, e.id);
          checkOutput("rsp_reason", rsp_fail_reason, e.reason);
        end else begin
          checkOutput("disp_strobe", {disp_valid, rsp_write_en}, 3'b100);
          checkOutput("disp_ch", disp_ch, e.ch);
          checkOutput("disp_id", disp_id, e.id);
          checkOutput("disp_page_idx", disp_page_idx, e.idx);
          checkOutput("disp_size", disp_size, e.size);
        end
        checkOutput("latency", cyc - last_pop_cycle, e.lat);
      end
    end
  end

  // Directed sequence of scenarios.
  initial begin
    cyc = 0; pop_count = 0; last_pop_cycle = 0; compared = 0; mismatched = 0;
    ovr0 = 0; ovr1 = 0;
    rst_n = 1'b0;
    rsp_almost_full = 2'b00;
    ch_blocked = 2'b00;
    req_id = '0; req_page_idx = '0; req_page_count = '0;
    refresh();
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_req_pop", req_pop, 0);
    checkOutput("rst_disp_valid", disp_valid, 0);
    checkOutput("rst_rsp_write_en", rsp_write_en, 0);
    checkOutput("rst_disp_fields", {disp_ch, disp_id, disp_page_idx, disp_size}, 0);
    checkOutput("rst_rsp_fields", {rsp_id, rsp_fail_reason}, 0);

    $display("[TB] single request ch0 count=3, earliest pop at cycle 2");
    applyStimulus(0, 8'h11, 20'h12345, 4'd3, 2, 1'b1);
    tick();
    rst_n = 1'b1;
    checkOutput("no_pop_cycle1", req_pop, 0);
    tick();
    checkOutput("pop_cycle2", req_pop, 2'b01);
    waitDrain(40);

    $display("[TB] same channel then channel switch, count=8");
    applyStimulus(0, 8'h21, 20'h00100, 4'd8, 2, 1'b1);
    waitDrain(40);
    applyStimulus(1, 8'h22, 20'h00200, 4'd8, 7, 1'b1);
    waitPop(40);
    rsp_almost_full[1] = 1'b1;
    waitDrain(40);
    rsp_almost_full[1] = 1'b0;

    $display("[TB] zero and over-max counts on ch0");
    applyStimulus(0, 8'h31, 20'h00300, 4'd0, 2, 1'b1);
    applyStimulus(0, 8'h32, 20'h00301, 4'd9, 2, 1'b1);
    waitDrain(40);
    tick();
    checkOutput("rsp_idle_zero", {rsp_id, rsp_fail_reason}, 0);
    applyStimulus(1, 8'h33, 20'h00400, 4'd1, 2, 1'b1);
    waitDrain(40);

    $display("[TB] urgent ch1 beats rr_ptr=0");
    ovr0 = 10; ovr1 = 64;
    applyStimulus(1, 8'h41, 20'h00500, 4'd5, 2, 1'b1);
    applyStimulus(0, 8'h42, 20'h00600, 4'd4, 7, 1'b1);
    waitDrain(60);
    ovr0 = 0; ovr1 = 0;
    refresh();

    $display("[TB] all channels blocked");
    ch_blocked = 2'b11;
    applyStimulus(1, 8'h51, 20'h00700, 4'd2, 7, 1'b0);
    snap = pop_count;
    repeat (20) tick();
    checkOutput("blocked_pops", pop_count - snap, 0);

    $display("[TB] reset during switch wait");
    ch_blocked = 2'b00;
    waitPop(40);
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_strobes", {req_pop, disp_valid, rsp_write_en}, 0);
    checkOutput("midrst_disp_fields", {disp_ch, disp_id, disp_page_idx, disp_size}, 0);
    checkOutput("midrst_rsp_fields", {rsp_id, rsp_fail_reason}, 0);
    rst_n = 1'b1;
    snap = pop_count;
    repeat (12) tick();
    checkOutput("midrst_no_pop", pop_count - snap, 0);

    $display("[TB] first dispatch after reset needs no switch gap");
    applyStimulus(1, 8'h61, 20'h00800, 4'd2, 2, 1'b1);
    waitDrain(40);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
